// File: rtl/output_channel_buffer_pkg.sv
// Shared datapath constants and the tagged-word entry type used by the
// channel buffers of the processing element.
package output_channel_buffer_pkg;

    localparam int TIA_OCT_WIDTH           = 4;
    localparam int TIA_WORD_WIDTH          = 32;
    localparam int TIA_NUM_OUTPUT_CHANNELS = 4;
    localparam int TIA_OUTPUT_BUFFER_DEPTH = 4;

    // Input channel buffers reuse this entry layout, so the field order is fixed.
    typedef struct packed {
        logic [TIA_OCT_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/output_channel_buffer.sv
// Show-ahead circular FIFO of tagged words between one enqueue source and a
// downstream consumer, with occupancy flags and a sticky overflow indicator.
module output_channel_buffer
    import output_channel_buffer_pkg::*;
#(
    parameter int DEPTH             = TIA_OUTPUT_BUFFER_DEPTH,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enqueue,
    input  logic [TIA_OCT_WIDTH-1:0]      enqueue_tag,
    input  logic [TIA_WORD_WIDTH-1:0]     enqueue_data,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [TIA_OCT_WIDTH-1:0]      output_tag,
    output logic [TIA_WORD_WIDTH-1:0]     output_data,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tagged_word_t      mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              deq;
    logic              enq_acc;

    assign output_valid = (count_q != '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (int'(count_q) >= ALMOST_FULL_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;

    // Head is gated when empty so stale storage never reaches the consumer.
    assign output_tag  = output_valid ? mem_q[rd_ptr_q].tag  : '0;
    assign output_data = output_valid ? mem_q[rd_ptr_q].data : '0;

    assign deq     = output_valid & output_ready;
    assign enq_acc = enqueue & (~full | deq);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (enqueue & full & ~deq);
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({enq_acc, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; the empty gating hides its contents.
    always_ff @(posedge clock) begin
        if (enq_acc) begin
            mem_q[wr_ptr_q] <= '{tag: enqueue_tag, data: enqueue_data};
        end
    end

endmodule

// File: tb/tb_output_channel_buffer.sv
// Scoreboard bench for output_channel_buffer: a reference queue is filled as
// words are accepted and drained as the DUT presents them to the consumer.
module tb_output_channel_buffer;
    import output_channel_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic                      clock;
    logic                      reset;
    logic                      enqueue;
    logic [TIA_OCT_WIDTH-1:0]  enqueue_tag;
    logic [TIA_WORD_WIDTH-1:0] enqueue_data;
    logic                      output_valid;
    logic                      output_ready;
    logic [TIA_OCT_WIDTH-1:0]  output_tag;
    logic [TIA_WORD_WIDTH-1:0] output_data;
    logic                      full;
    logic                      almost_full;
    logic [2:0]                count;
    logic                      overflow;

    int compared   = 0;
    int mismatched = 0;
    int popCount   = 0;

    tagged_word_t sbQ[$];
    tagged_word_t monExp;
    int           modelCount = 0;
    logic         mDeq, mAcc;

    output_channel_buffer #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .enqueue      (enqueue),
        .enqueue_tag  (enqueue_tag),
        .enqueue_data (enqueue_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_tag   (output_tag),
        .output_data  (output_data),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference occupancy model: pushes every word the buffer should accept.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sbQ.delete();
            modelCount = 0;
        end else begin
            mDeq = (modelCount > 0) && output_ready;
            mAcc = enqueue && ((modelCount < DEPTH) || mDeq);
            if (mAcc) sbQ.push_back('{tag: enqueue_tag, data: enqueue_data});
            modelCount = modelCount + int'(mAcc) - int'(mDeq);
        end
    end

    // Every handshake seen on the falling edge must match the oldest expected word.
    always @(negedge clock) begin
        if (reset && output_valid && output_ready) begin
            compared++;
            if (sbQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL pop_unexpected: got tag=%0h data=%0h, required no output", output_tag, output_data);
            end else begin
                monExp = sbQ.pop_front();
                popCount++;
                if ({output_tag, output_data} !== monExp) begin
                    mismatched++;
                    $display("[TB] FAIL pop_order: got tag=%0h data=%0h, required tag=%0h data=%0h",
                             output_tag, output_data, monExp.tag, monExp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [TIA_OCT_WIDTH-1:0] tag,
                                 input logic [TIA_WORD_WIDTH-1:0] data, input logic rdy);
        enqueue      = en;
        enqueue_tag  = tag;
        enqueue_data = data;
        output_ready = rdy;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 4'h7, 32'hDEAD, 1'b1);
        reset = 1'b0;
        #1;
        compared++;
        if ({output_valid, full, almost_full, overflow, count, output_tag, output_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got v=%b f=%b af=%b ov=%b cnt=%0d tag=%0h data=%0h, required all 0",
                     output_valid, full, almost_full, overflow, count, output_tag, output_data);
        end
        tick();
        tick();
        enqueue = 1'b0;
        reset = 1'b1;
        compared++;
        if (count !== 3'd0 || output_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_edge_enqueue: got cnt=%0d v=%b, required cnt=0 v=0", count, output_valid);
        end
    endtask

    task automatic test_first_word();
        doReset();
        applyStimulus(1'b1, 4'h1, 32'hA5, 1'b0);
        #3;
        compared++;
        if (output_valid !== 1'b0 || output_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL no_bypass: got v=%b data=%0h, required v=0 data=0", output_valid, output_data);
        end
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        compared++;
        if (output_valid !== 1'b1 || output_tag !== 4'h1 || output_data !== 32'hA5 || count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL first_word: got v=%b tag=%0h data=%0h cnt=%0d, required v=1 tag=1 data=a5 cnt=1",
                     output_valid, output_tag, output_data, count);
        end
        drain(1);
    endtask

    task automatic test_fill_overflow();
        logic [2:0] expCnt;
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 32'h10 + 32'(i), 1'b0);
            tick();
            expCnt = 3'(i + 1);
            compared++;
            if (count !== expCnt || almost_full !== (i + 1 >= 3) || full !== (i + 1 == DEPTH)) begin
                mismatched++;
                $display("[TB] FAIL fill_flags: got cnt=%0d af=%b f=%b, required cnt=%0d af=%b f=%b",
                         count, almost_full, full, expCnt, (i + 1 >= 3), (i + 1 == DEPTH));
            end
        end
        applyStimulus(1'b1, 4'hE, 32'hEE, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        compared++;
        if (overflow !== 1'b1 || count !== 3'd4 || output_tag !== 4'h1 || output_data !== 32'h10) begin
            mismatched++;
            $display("[TB] FAIL overflow_drop: got ov=%b cnt=%0d tag=%0h data=%0h, required ov=1 cnt=4 tag=1 data=10",
                     overflow, count, output_tag, output_data);
        end
        drain(DEPTH);
        compared++;
        if (overflow !== 1'b1 || output_valid !== 1'b0 || output_data !== '0 || sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL overflow_sticky: got ov=%b v=%b data=%0h pending=%0d, required ov=1 v=0 data=0 pending=0",
                     overflow, output_valid, output_data, sbQ.size());
        end
    endtask

    task automatic test_full_simultaneous();
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'h2, 32'h20 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 4'h3, 32'h55, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        compared++;
        if (count !== 3'd4 || overflow !== 1'b0 || output_data !== 32'h21 || full !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL full_simul: got cnt=%0d ov=%b data=%0h f=%b, required cnt=4 ov=0 data=21 f=1",
                     count, overflow, output_data, full);
        end
        drain(DEPTH);
    endtask

    task automatic test_streaming();
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i), 32'(i), 1'b1);
            tick();
            compared++;
            if (count !== 3'd1 || output_data !== 32'(i) || output_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL stream_%0d: got cnt=%0d data=%0h v=%b, required cnt=1 data=%0h v=1",
                         i, count, output_data, output_valid, i);
            end
        end
        drain(1);
        compared++;
        if (count !== 3'd0 || popCount < 10) begin
            mismatched++;
            $display("[TB] FAIL stream_drain: got cnt=%0d pops=%0d, required cnt=0 pops>=10", count, popCount);
        end
    endtask

    task automatic test_back_to_back_reset();
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h9, 32'h90 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        compared++;
        if (output_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_reset: got v=%b cnt=%0d f=%b ov=%b, required all 0",
                     output_valid, count, full, overflow);
        end
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 4'h5, 32'h3C, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        compared++;
        if (output_data !== 32'h3C || output_tag !== 4'h5 || count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL post_reset_head: got tag=%0h data=%0h cnt=%0d, required tag=5 data=3c cnt=1",
                     output_tag, output_data, count);
        end
        drain(1);
    endtask

    task automatic test_empty_simultaneous();
        doReset();
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        compared++;
        if (count !== 3'd1 || output_valid !== 1'b1 || output_tag !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL empty_simul: got cnt=%0d v=%b tag=%0h, required cnt=1 v=1 tag=0",
                     count, output_valid, output_tag);
        end
        drain(1);
        drain(1);
        compared++;
        if (count !== 3'd0 || sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL empty_ready_noop: got cnt=%0d pending=%0d, required cnt=0 pending=0", count, sbQ.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #2;
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_full_simultaneous();
        test_streaming();
        test_back_to_back_reset();
        test_empty_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/output_channel_buffer.md
OUTPUT_CHANNEL_BUFFER -- requirements
Module: output_channel_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of tagged words held; power of two, at least 2.
REQ-002 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-1, occupancy at which almost_full asserts.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enqueue  input  1  one enqueue signal from the enqueueing unit for this channel.
REQ-006 enqueue_tag  input  TIA_OCT_WIDTH  tag accompanying enqueue.
REQ-007 enqueue_data  input  TIA_WORD_WIDTH  datapath result to buffer.
REQ-008 output_valid  output  1  head entry present on output_tag/output_data.
REQ-009 output_ready  input  1  downstream consumer accepts head this cycle.
REQ-010 output_tag  output  TIA_OCT_WIDTH  tag of head entry.
REQ-011 output_data  output  TIA_WORD_WIDTH  data of head entry.
REQ-012 full  output  1  occupancy equals DEPTH.
REQ-013 almost_full  output  1  occupancy at least ALMOST_FULL_LEVEL; used by trigger resolution to block instructions targeting this channel.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky; enqueue attempted while full with no same-cycle dequeue.

Function
REQ-016 Circular buffer of DEPTH {tag, data} entries; read and write pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-017 Enqueue accepted when enqueue=1 and (full=0, or a dequeue occurs in the same cycle).
REQ-018 Dequeue occurs when output_valid=1 and output_ready=1; read pointer advances one.
REQ-019 Show-ahead output: output_tag/output_data driven combinationally from head entry; zero when empty.
REQ-020 Latency: word enqueued on edge N visible with output_valid=1 after edge N; no same-cycle bypass from enqueue inputs when empty.
REQ-021 Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-022 Simultaneous enqueue and dequeue when full: both accepted, count stays DEPTH, overflow not set.
REQ-023 Simultaneous enqueue and dequeue when empty: enqueue accepted, dequeue impossible (output_valid=0), count becomes 1.
REQ-024 Enqueue when full without dequeue: word dropped, buffer contents and pointers unchanged, overflow set on that edge, remaining set until reset.
REQ-025 output_ready while empty: no effect.
REQ-026 Tag stored unmodified; tag value 0 is a legal tag.
REQ-027 full, almost_full, output_valid derived from count, no added latency.

Reset
REQ-028 On reset low, asynchronously: pointers 0, count 0, output_valid 0, full 0, almost_full 0 (unless ALMOST_FULL_LEVEL is 0), overflow 0, output_tag/output_data 0.
REQ-029 Storage array contents need not be reset; never observable because output gated when empty.
REQ-030 Reset asserted mid-operation discards all buffered entries; first enqueue after release lands at index 0.
REQ-031 No enqueue or dequeue accepted on the first rising edge coinciding with reset low.

Structure
REQ-032 TIA_OCT_WIDTH, TIA_WORD_WIDTH, TIA_NUM_OUTPUT_CHANNELS and default TIA_OUTPUT_BUFFER_DEPTH SHALL come from the shared datapath package header.
REQ-033 A packed {tag, data} entry typedef SHALL live in the shared package for reuse by the input channel buffers.
REQ-034 Single module, no sub-modules; instantiated TIA_NUM_OUTPUT_CHANNELS times in the processing element, one per enqueue signal.

Verification
REQ-035 Reset, then enqueue tag=1 data=0xA5 one cycle, ready=0 -> next cycle valid=1, tag=1, data=0xA5, count=1.
REQ-036 DEPTH=4: enqueue 4 words ready=0 -> full=1, almost_full asserted at count 3; 5th enqueue -> dropped, overflow=1, head unchanged.
REQ-037 Full, enqueue 0x55 with ready=1 same cycle -> head advances, count stays 4, overflow=0, 0x55 last out.
REQ-038 Continuous enqueue and ready=1 for 10 cycles, data 0..9 -> outputs 0..9 in order with one-cycle latency, pointers wrap twice, count stays 1.
REQ-039 Three entries held, reset low mid-cycle -> valid, count, full, overflow 0 immediately; after release, enqueue 0x3C -> head 0x3C.
REQ-040 Empty, ready=1 and enqueue tag=0 data=0 same cycle -> count 1, valid=1 next cycle, no underflow.
